serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor built around a DIGIT-bit full-adder slice.
- The slice is reused over WIDTH/DIGIT clock cycles, with the carry held in a register between cycles.
- Uses a start/done handshake and reports carry-out and signed overflow.
- Serves as the area-cheap arithmetic unit for datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. Must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0; any other value is an elaboration error.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a new operation; sampled only when not busy.
- a, input, WIDTH: operand A; captured on the accepting edge.
- b, input, WIDTH: operand B; captured on the accepting edge.
- cin, input, 1: carry-in for add, borrow-in for subtract; captured on the accepting edge.
- sub, input, 1: 0 = add (a + b + cin); 1 = subtract (a − b − cin); captured on the accepting edge.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse; results are valid from this cycle onward.
- sum, output, WIDTH: result, modulo 2^WIDTH.
- cout, output, 1: raw carry out of the MSB. For subtract, 1 means no borrow.
- ovf, output, 1: two's-complement signed overflow.

Behaviour:
- Let N = WIDTH/DIGIT.
- Arithmetic:
  - Add: computes a + b + cin.
  - Subtract: computes a + ~b + ~cin.
  - cout: carry out of bit WIDTH−1.
  - ovf: (opA[MSB] == opB_eff[MSB]) && (sum[MSB] != opA[MSB]), where opB_eff is b for add and ~b for subtract.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - FIN: busy=0, done=1, lasts exactly one cycle.
- Transitions:
  - IDLE → RUN when start=1. On that edge: latch a, b (or ~b), carry register = cin (or ~cin), step counter = 0.
  - RUN: each edge adds the low DIGIT bits of the A/B shift registers plus the carry register. Then:
    - shift the DIGIT result bits into the MSB end of the result shift register;
    - update the carry register;
    - shift A and B right by DIGIT;
    - increment the counter.
  - RUN → FIN on the edge completing step N−1. On that same edge, sum/cout/ovf output registers are loaded.
  - FIN → RUN if start=1 (back-to-back accept, same latching as from IDLE); otherwise FIN → IDLE.
- Latency: start high in cycle t (IDLE or FIN) gives done=1 in cycle t+N+1. Throughput is one operation per N+1 cycles.
- start while in RUN is ignored; it is neither queued nor latched. Operand changes during RUN have no effect.
- sum/cout/ovf hold the previous result throughout RUN. They change only on the RUN→FIN edge or on reset.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0. Internal shift registers, carry and counter are also cleared.
- Reset asserted in any state, including mid-RUN, aborts the operation: no done pulse, outputs cleared on that edge. rst takes priority over start on the same edge.
- Counter width: clog2(N) bits, minimum 1. With N=1, RUN lasts one cycle.

Test Plan (WIDTH=8, DIGIT=1 unless noted):
- Add 8'h00 + 8'h00, cin=0, start in cycle 0 → done=1 only in cycle 9; sum=8'h00, cout=0, ovf=0; busy high in cycles 1–8.
- Add 8'hFF + 8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Then add 8'h7F + 8'h01 → sum=8'h80, cout=0, ovf=1. sum holds 8'h00 during the second RUN.
- Subtract 8'h05 − 8'h07, cin=0 → sum=8'hFE, cout=0, ovf=0. Subtract 8'h80 − 8'h01 → sum=8'h7F, cout=1, ovf=1. Subtract 8'h10 − 8'h0F, cin=1 → sum=8'h00, cout=1, ovf=0.
- start held high with changing a/b during RUN → result reflects only the operands captured on the accepting edge. start=1 in the FIN cycle → new operation accepted; second done pulse exactly 9 cycles later; no idle gap.
- rst=1 in cycle 4 of a RUN (add 8'h7F + 8'h01) → next cycle busy=0, sum=0, cout=0, ovf=0; no done pulse within 20 cycles; a fresh start afterwards completes normally.
- DIGIT=4 build: add 8'hAA + 8'h55, cin=1 → sum=8'h00, cout=1, ovf=0, done in cycle t+3. DIGIT=8 build: same stimulus → done in cycle t+2.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Start/done handshake and operand/result bundle for the digit-serial adder/subtractor.
// The requester drives the master side; the arithmetic unit takes the slave side.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice reused over WIDTH/DIGIT cycles,
// carry held in a register between steps, results registered on completion.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input logic            clk,
    input logic            rst,
    serial_addsub_if.slave bus
);
    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_addsub: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q, ovf_q;

    logic [DIGIT-1:0]  slice_s;
    logic              slice_c;
    logic [WIDTH-1:0]  res_d;
    logic              last_step;
    logic              accept;

    assign {slice_c, slice_s} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                              + (DIGIT + 1)'(carry_q);
    // New digits enter at the MSB end; after N steps the result is fully aligned.
    assign res_d     = WIDTH'({slice_s, res_q} >> DIGIT);
    assign last_step = (cnt_q == CntW'(N - 1));
    assign accept    = bus.start && (state_q != StRun);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = bus.start ? StRun : StIdle;
            StRun:   state_d = last_step ? StFin : StRun;
            StFin:   state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = (state_q == StFin);
        bus.sum  = sum_q;
        bus.cout = cout_q;
        bus.ovf  = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtract folds into add: a + ~b + ~borrow.
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? ~bus.cin : bus.cin;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            res_q   <= res_d;
            carry_q <= slice_c;
            cnt_q   <= cnt_q + 1'b1;
            if (last_step) begin
                // On the final step the low digit of a_q/b_q holds the operand MSBs.
                sum_q  <= res_d;
                cout_q <= slice_c;
                ovf_q  <= (a_q[DIGIT-1] == b_q[DIGIT-1]) && (slice_s[DIGIT-1] != a_q[DIGIT-1]);
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: DIGIT=1, 4 and 8 builds side by side, expected
// results queued at start and compared when done pulses.
module tb_serial_addsub;
    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    res_t q1[$];
    res_t q4[$];
    res_t q8[$];

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) if1 ();
    serial_addsub_if #(.WIDTH(8)) if4 ();
    serial_addsub_if #(.WIDTH(8)) if8 ();

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        logic [7:0] be;
        logic [8:0] t;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {8'b0, (sub ? ~cin : cin)};
        model.sum  = t[7:0];
        model.cout = t[8];
        model.ovf  = (a[7] == be[7]) && (t[7] != a[7]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input res_t exp);
        if1.a = a; if1.b = b; if1.cin = cin; if1.sub = sub; if1.start = 1'b1;
        q1.push_back(exp);
        tick();
        if1.start = 1'b0;
    endtask

    task automatic wait_done1(output res_t got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 30; i++) begin
            if (if1.done === 1'b1) begin
                got = {if1.sum, if1.cout, if1.ovf};
                ok  = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        res_t r;
        rst = 1'b1;
        tick();
        tick();
        r = {if1.sum, if1.cout, if1.ovf};
        checks++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b, want 0 0", if1.busy, if1.done);
        end
        checks++;
        if (r !== res_t'(0)) begin
            errors++;
            $display("FAIL reset_result: got %h, want 0", r);
        end
        checks++;
        if ({if4.busy, if4.done, if8.busy, if8.done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_wide: got %b, want 0000",
                     {if4.busy, if4.done, if8.busy, if8.done});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_timing();
        res_t got, exp;
        start1(8'h00, 8'h00, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b0, ovf: 1'b0});
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (if1.busy !== (c <= 8) || if1.done !== (c == 9)) begin
                errors++;
                $display("FAIL timing_c%0d: busy=%b done=%b, want %b %b",
                         c, if1.busy, if1.done, c <= 8, c == 9);
            end
            if (c == 9) begin
                got = {if1.sum, if1.cout, if1.ovf};
                exp = q1.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL add_zero: got %h, want %h", got, exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_add_edges();
        res_t got, exp;
        bit   ok;
        start1(8'hFF, 8'h01, 1'b0, 1'b0, '{sum: 8'h00, cout: 1'b1, ovf: 1'b0});
        wait_done1(got, ok);
        exp = q1.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL add_ff_01: got %h ok=%b, want %h", got, ok, exp);
        end
        start1(8'h7F, 8'h01, 1'b0, 1'b0, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
        for (int i = 0; i < 20 && if1.done !== 1'b1; i++) begin
            checks++;
            if (if1.sum !== 8'h00) begin
                errors++;
                $display("FAIL sum_hold: got %h, want 00", if1.sum);
            end
            tick();
        end
        wait_done1(got, ok);
        exp = q1.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL add_7f_01: got %h ok=%b, want %h", got, ok, exp);
        end
    endtask

    task automatic test_sub();
        res_t got, exp;
        bit   ok;
        logic [7:0] av[3] = '{8'h05, 8'h80, 8'h10};
        logic [7:0] bv[3] = '{8'h07, 8'h01, 8'h0F};
        logic       cv[3] = '{1'b0, 1'b0, 1'b1};
        res_t       ev[3] = '{'{8'hFE, 1'b0, 1'b0}, '{8'h7F, 1'b1, 1'b1}, '{8'h00, 1'b1, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            start1(av[i], bv[i], cv[i], 1'b1, ev[i]);
            wait_done1(got, ok);
            exp = q1.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL sub_%0d: got %h ok=%b, want %h", i, got, ok, exp);
            end
        end
    endtask

    task automatic test_random();
        res_t got, exp;
        bit   ok;
        logic [7:0] a, b;
        logic cin, sub;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            start1(a, b, cin, sub, model(a, b, cin, sub));
            wait_done1(got, ok);
            exp = q1.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL rand_%0d %h %s %h c%b: got %h ok=%b, want %h",
                         i, a, sub ? "-" : "+", b, cin, got, ok, exp);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        if1.a = 8'h12; if1.b = 8'h34; if1.cin = 1'b0; if1.sub = 1'b0; if1.start = 1'b1;
        q1.push_back('{sum: 8'h46, cout: 1'b0, ovf: 1'b0});
        tick();
        for (int c = 1; c <= 8; c++) begin
            if1.a = 8'($urandom); if1.b = 8'($urandom); if1.sub = 1'($urandom);
            if1.start = 1'b1;
            checks++;
            if (if1.busy !== 1'b1 || if1.done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_run_c%0d: busy=%b done=%b, want 1 0", c, if1.busy, if1.done);
            end
            tick();
        end
        checks++;
        if (if1.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done1: done=%b, want 1", if1.done);
        end
        got = {if1.sum, if1.cout, if1.ovf};
        exp = q1.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_result1: got %h, want %h", got, exp);
        end
        if1.a = 8'h80; if1.b = 8'h01; if1.cin = 1'b0; if1.sub = 1'b1; if1.start = 1'b1;
        q1.push_back('{sum: 8'h7F, cout: 1'b1, ovf: 1'b1});
        tick();
        if1.start = 1'b0;
        checks++;
        if (if1.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_gap: busy=%b, want 1", if1.busy);
        end
        for (int c = 10; c <= 17; c++) begin
            checks++;
            if (if1.done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_early_done_c%0d: done=%b, want 0", c, if1.done);
            end
            tick();
        end
        got = {if1.sum, if1.cout, if1.ovf};
        exp = q1.pop_front();
        checks++;
        if (if1.done !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL b2b_result2: done=%b got %h, want 1 %h", if1.done, got, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        res_t got, exp;
        bit   ok;
        bit   saw_done;
        if1.a = 8'h7F; if1.b = 8'h01; if1.cin = 1'b0; if1.sub = 1'b0; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (if1.busy !== 1'b1 || if1.sum !== 8'h7F) begin
            errors++;
            $display("FAIL pre_reset: busy=%b sum=%h, want 1 7f", if1.busy, if1.sum);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = {if1.sum, if1.cout, if1.ovf};
        checks++;
        if (if1.busy !== 1'b0 || got !== res_t'(0)) begin
            errors++;
            $display("FAIL mid_reset: busy=%b got %h, want 0 0", if1.busy, got);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if1.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: saw done=1, want none");
        end
        rst = 1'b1; if1.start = 1'b1;
        tick();
        rst = 1'b0; if1.start = 1'b0;
        checks++;
        if (if1.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_start: busy=%b, want 0", if1.busy);
        end
        start1(8'h7F, 8'h01, 1'b0, 1'b0, '{sum: 8'h80, cout: 1'b0, ovf: 1'b1});
        wait_done1(got, ok);
        exp = q1.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL post_reset_op: got %h ok=%b, want %h", got, ok, exp);
        end
        tick();
    endtask

    task automatic test_digit();
        res_t got, exp;
        logic [7:0] a, b;
        logic cin, sub;
        for (int v = 0; v < 6; v++) begin
            if (v == 0) begin
                a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
            exp = (v == 0) ? '{sum: 8'h00, cout: 1'b1, ovf: 1'b0} : model(a, b, cin, sub);
            if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub; if4.start = 1'b1;
            if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; if8.start = 1'b1;
            q4.push_back(exp);
            q8.push_back(exp);
            tick();
            if4.start = 1'b0; if8.start = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                checks++;
                if (if4.done !== (c == 3) || if8.done !== (c == 2)) begin
                    errors++;
                    $display("FAIL digit_lat_v%0d_c%0d: done4=%b done8=%b, want %b %b",
                             v, c, if4.done, if8.done, c == 3, c == 2);
                end
                if (c == 2) begin
                    got = {if8.sum, if8.cout, if8.ovf};
                    exp = q8.pop_front();
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL digit8_v%0d: got %h, want %h", v, got, exp);
                    end
                end
                if (c == 3) begin
                    got = {if4.sum, if4.cout, if4.ovf};
                    exp = q4.pop_front();
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL digit4_v%0d: got %h, want %h", v, got, exp);
                    end
                end
                tick();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.sub = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.sub = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.sub = 1'b0;
        test_reset();
        test_timing();
        test_add_edges();
        test_sub();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_digit();
        checks++;
        if (q1.size() != 0 || q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left %0d/%0d/%0d, want 0/0/0",
                     q1.size(), q4.size(), q8.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
